// File: rtl/bus_pkg.sv
// Shared types and constants for the bus-side memory responder.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resp_state_t;

    localparam logic [31:0] BAD_DATA   = 32'hBAD0_BAD0;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/bus_mem_array.sv
// Word-addressed storage with one write port and a registered read port.
module bus_mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Single-word bus responder: latches a request in IDLE, stays busy for
// LATENCY cycles, then performs the RAM access and pulses done for one cycle.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_rdata,
    output logic        bus_full,
    output logic        bus_done,
    output logic        bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int OB = $clog2(WORD_BYTES);

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
        logic          wr;
        logic          inr;
        logic          err;
    } req_t;

    resp_state_t   state, state_nxt;
    logic [3:0]    cnt;
    req_t          req;
    logic          in_range, misaligned, accept, last, mem_we;
    logic [AW-1:0] idx, mem_raddr;
    logic [31:0]   mem_rdata;

    // BASE_ADDR is aligned to the array size, so range is a tag compare.
    assign in_range   = (bus_addr[31:AW+OB] == BASE_ADDR[31:AW+OB]);
    assign misaligned = (bus_addr[OB-1:0] != '0);
    assign idx        = bus_addr[AW+OB-1:OB];
    assign accept     = (state == IDLE) && (bus_read || bus_write);
    assign last       = (state == BUSY) && (cnt == 4'd0);
    assign mem_we     = last && req.wr && req.inr;

    // Read address tracks the live bus in IDLE so LATENCY=1 still has data ready.
    assign mem_raddr  = (state == IDLE) ? idx : req.idx;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus_read || bus_write) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req       <= '0;
            bus_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req.idx   <= idx;
                req.wdata <= bus_wdata;
                req.wr    <= bus_write;
                req.inr   <= in_range;
                req.err   <= !in_range || misaligned || (bus_read && bus_write);
                cnt       <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (last && !req.wr)
                bus_rdata <= req.inr ? mem_rdata : BAD_DATA;
        end
    end

    assign bus_full = (state == BUSY);
    assign bus_done = (state == DONE);
    assign bus_err  = (state == DONE) && req.err;

    bus_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (req.idx),
        .raddr (mem_raddr),
        .wdata (req.wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench: expected read data / error pushed at request, checked at done.
module tb_bus_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic        bus_read = 1'b0, bus_write = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_full, bus_done, bus_err;

    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic        r1_read = 1'b0, r1_write = 1'b0;
    logic [31:0] o1_rdata;
    logic        o1_full, o1_done, o1_err;

    always #5 clk = ~clk;

    bus_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata),
        .bus_full(bus_full), .bus_done(bus_done), .bus_err(bus_err)
    );

    bus_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .bus_addr(r1_addr), .bus_wdata(r1_wdata),
        .bus_read(r1_read), .bus_write(r1_write), .bus_rdata(o1_rdata),
        .bus_full(o1_full), .bus_done(o1_done), .bus_err(o1_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [int];
    logic [31:0] mdl_rdata = '0;
    int          n_chk = 0, n_err = 0;
    int          full_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference behaviour for a 256-word RAM at base 0 (1 KiB window).
    task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic inr;
        int   idx;
        exp_t e;
        inr = (addr[31:10] == 22'd0);
        idx = int'(addr[9:2]);
        if (wr) begin
            if (inr) mdl_mem[idx] = wdata;
        end else if (rd) begin
            mdl_rdata = inr ? mdl_mem[idx] : 32'hBAD0_BAD0;
        end
        e.rdata = mdl_rdata;
        e.err   = !inr || (addr[1:0] != 2'd0) || (rd && wr);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            full_cnt = 0;
        end else begin
            if (bus_full) full_cnt++;
            if (bus_done) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", bus_rdata, e.rdata);
                    chk("err", 32'(bus_err), 32'(e.err));
                    chk("full_cycles", full_cnt, LAT);
                end
                full_cnt = 0;
            end else if (bus_err) begin
                chk("err_without_done", 32'(bus_err), 32'd0);
            end
        end
    end

    // Called at the negedge of the first BUSY cycle; returns at the negedge after done.
    task automatic wait_done();
        int i;
        for (i = 0; i < 20; i++) begin
            if (bus_done) break;
            @(negedge clk);
        end
        if (!bus_done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_latency", i, LAT);
            @(negedge clk);
            chk("done_pulse", 32'(bus_done), 32'd0);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        @(negedge clk);
        bus_read = rd; bus_write = wr; bus_addr = addr; bus_wdata = wdata;
        model(rd, wr, addr, wdata);
        @(negedge clk);
        // Scramble inputs while busy; only the latched request may be used.
        bus_read = 1'b0; bus_write = 1'b0;
        bus_addr = $urandom; bus_wdata = $urandom;
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_full", 32'(bus_full), 32'd0);
        chk("rst_done", 32'(bus_done), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b0;

        access(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        access(1'b1, 1'b0, 32'h21, 32'h0);          // misaligned read
        access(1'b0, 1'b1, 32'h0, 32'h1357_9BDF);
        access(1'b1, 1'b0, 32'h400, 32'h0);         // out of range read
        access(1'b0, 1'b1, 32'h400, 32'hFFFF_0000); // dropped, aliases word 0
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5);   // write wins, err
        access(1'b1, 1'b0, 32'h8, 32'h0);
        access(1'b0, 1'b1, 32'h10, 32'h1111_1111);

        // Reset in the middle of a write: the write must be discarded.
        @(negedge clk);
        bus_write = 1'b1; bus_addr = 32'h10; bus_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_write = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_full", 32'(bus_full), 32'd0);
        chk("mid_rst_done", 32'(bus_done), 32'd0);
        chk("mid_rst_err", 32'(bus_err), 32'd0);
        chk("mid_rst_rdata", bus_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_rdata = 32'd0;
        access(1'b1, 1'b0, 32'h10, 32'h0);

        // Strobe held through DONE: a second access follows one idle cycle later.
        @(negedge clk);
        bus_read = 1'b1; bus_addr = 32'h20;
        model(1'b1, 1'b0, 32'h20, 32'h0);
        model(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        wait_done();
        chk("held_idle_full", 32'(bus_full), 32'd0);
        @(negedge clk);
        chk("held_restart_full", 32'(bus_full), 32'd1);
        bus_read = 1'b0;
        wait_done();
        for (int k = 0; k < 3; k++) begin
            chk("dropped_stays_idle", 32'(bus_full), 32'd0);
            @(negedge clk);
        end
        chk("sb_drained", sb.size(), 32'd0);

        // LATENCY=1 build: one busy cycle, inputs scrambled while busy.
        r1_write = 1'b1; r1_addr = 32'h40; r1_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        r1_write = 1'b0; r1_addr = 32'h44; r1_wdata = 32'h0;
        chk("l1_w_full", 32'(o1_full), 32'd1);
        @(negedge clk);
        chk("l1_w_done", 32'(o1_done), 32'd1);
        chk("l1_w_full_off", 32'(o1_full), 32'd0);
        @(negedge clk);
        r1_read = 1'b1; r1_addr = 32'h40;
        @(negedge clk);
        r1_read = 1'b0; r1_addr = 32'h44;
        chk("l1_r_full", 32'(o1_full), 32'd1);
        @(negedge clk);
        chk("l1_r_done", 32'(o1_done), 32'd1);
        chk("l1_r_full_off", 32'(o1_full), 32'd0);
        chk("l1_r_rdata", o1_rdata, 32'hCAFE_F00D);
        chk("l1_r_err", 32'(o1_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
